// File: rtl/lfa_adc_sampler_if.sv
// SPI bus between the LFA sampler (master) and the ADC128S022 (slave).
interface lfa_adc_sampler_if;
  logic adc_cs_n;
  logic adc_sck;
  logic adc_din;
  logic adc_dout;

  modport master (output adc_cs_n, output adc_sck, output adc_din, input adc_dout);
  modport slave  (input adc_cs_n, input adc_sck, input adc_din, output adc_dout);
endinterface

// File: rtl/lfa_adc_sampler.sv
// Scans the left/middle/right line sensors on an ADC128S022 and presents
// registered 12-bit results plus a one-cycle strobe per complete scan.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_GAP   | cs_n high for FRAME_GAP cycles between frames
// ST_FRAME | cs_n low, 16 SCLK periods (32 clk), address out / data in
// ST_LATCH | cs_n high, store previous channel's result, advance pointer
module lfa_adc_sampler #(
  parameter logic [2:0] CH_LEFT   = 3'd3,
  parameter logic [2:0] CH_MIDDLE = 3'd2,
  parameter logic [2:0] CH_RIGHT  = 3'd1,
  parameter int         FRAME_GAP = 2
) (
  input  logic                      clk_3125KHz,
  input  logic                      rst,
  lfa_adc_sampler_if.master         adc,
  output logic [11:0]               left,
  output logic [11:0]               middle,
  output logic [11:0]               right,
  output logic                      sample_valid
);

  typedef enum logic [1:0] {ST_GAP, ST_FRAME, ST_LATCH} state_t;

  localparam logic [1:0] PTR_LEFT   = 2'd0;
  localparam logic [1:0] PTR_MIDDLE = 2'd1;
  localparam logic [1:0] PTR_RIGHT  = 2'd2;
  localparam logic [4:0] GAP_LOAD   = 5'(FRAME_GAP - 1);
  localparam logic [4:0] FRAME_LOAD = 5'd31;

  state_t      state_q, state_nxt;
  logic [4:0]  cnt_q, cnt_nxt;
  logic [1:0]  ptr_q, prev_q;
  logic        primed_q;
  logic [11:0] shift_q;
  logic [2:0]  addr;
  logic [15:0] ctrl;
  logic        sample_edge;
  logic        cs_n_nxt, sck_nxt, din_nxt;

  always_comb begin
    case (ptr_q)
      PTR_LEFT:   addr = CH_LEFT;
      PTR_MIDDLE: addr = CH_MIDDLE;
      default:    addr = CH_RIGHT;
    endcase
    ctrl = {2'b00, addr, 11'b0};
  end

  // cnt counts down 31..0 in FRAME; odd cnt is the low half of an SCLK period
  // and cnt[4:1] equals 15-k, so it indexes ctrl directly.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      ST_GAP: begin
        if (cnt_q == 5'd0) begin
          state_nxt = ST_FRAME;
          cnt_nxt   = FRAME_LOAD;
        end else begin
          cnt_nxt = cnt_q - 5'd1;
        end
      end
      ST_FRAME: begin
        if (cnt_q == 5'd0) state_nxt = ST_LATCH;
        else               cnt_nxt   = cnt_q - 5'd1;
      end
      ST_LATCH: begin
        state_nxt = ST_GAP;
        cnt_nxt   = GAP_LOAD;
      end
      default: begin
        state_nxt = ST_GAP;
        cnt_nxt   = GAP_LOAD;
      end
    endcase

    cs_n_nxt = (state_nxt != ST_FRAME);
    sck_nxt  = !((state_nxt == ST_FRAME) && cnt_nxt[0]);
    din_nxt  = (state_nxt == ST_FRAME) && ctrl[cnt_nxt[4:1]];
  end

  // The clk edge ending a low SCLK half is the one that raises SCLK.
  assign sample_edge = (state_q == ST_FRAME) && cnt_q[0] && (cnt_q[4:1] <= 4'd11);

  always_ff @(posedge clk_3125KHz) begin
    if (rst) begin
      state_q      <= ST_GAP;
      cnt_q        <= GAP_LOAD;
      adc.adc_cs_n <= 1'b1;
      adc.adc_sck  <= 1'b1;
      adc.adc_din  <= 1'b0;
      shift_q      <= 12'd0;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      adc.adc_cs_n <= cs_n_nxt;
      adc.adc_sck  <= sck_nxt;
      adc.adc_din  <= din_nxt;
      if (sample_edge) shift_q <= {shift_q[10:0], adc.adc_dout};
    end
  end

  // Each frame returns the conversion for the address sent one frame earlier.
  always_ff @(posedge clk_3125KHz) begin
    if (rst) begin
      left         <= 12'd0;
      middle       <= 12'd0;
      right        <= 12'd0;
      sample_valid <= 1'b0;
      ptr_q        <= PTR_LEFT;
      prev_q       <= PTR_LEFT;
      primed_q     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (state_q == ST_LATCH) begin
        if (primed_q) begin
          case (prev_q)
            PTR_LEFT:   left   <= shift_q;
            PTR_MIDDLE: middle <= shift_q;
            PTR_RIGHT:  right  <= shift_q;
            default:    ;
          endcase
          sample_valid <= (prev_q == PTR_RIGHT);
        end
        primed_q <= 1'b1;
        prev_q   <= ptr_q;
        ptr_q    <= (ptr_q == PTR_RIGHT) ? PTR_LEFT : ptr_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_lfa_adc_sampler.sv
// Directed bench for lfa_adc_sampler with a behavioural ADC128S022 model.
module tb_lfa_adc_sampler;
  logic        clk_3125KHz = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] left, middle, right;
  logic        sample_valid;
  logic        dout_mdl = 1'b0;

  lfa_adc_sampler_if bus ();
  assign bus.adc_dout = dout_mdl;

  lfa_adc_sampler dut (
    .clk_3125KHz (clk_3125KHz),
    .rst         (rst),
    .adc         (bus),
    .left        (left),
    .middle      (middle),
    .right       (right),
    .sample_valid(sample_valid)
  );

  always #160 clk_3125KHz = ~clk_3125KHz;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ADC model: data for the address captured in the previous complete frame
  logic [11:0] chan [8];
  logic [3:0]  lead = 4'h0;
  logic [2:0]  next_addr = 3'd0;
  logic [2:0]  cap;
  logic [15:0] word;
  logic        prev_cs_n = 1'b1, prev_sck = 1'b1;
  int          falls = 0, rises = 0, lows = 0;
  int          frames_done = 0;
  int          din_hi_idle = 0;
  logic [2:0]  rec_addr [$];
  int          rec_falls [$];
  int          rec_lows [$];

  always @(negedge clk_3125KHz) begin
    if (!bus.adc_cs_n) begin
      if (prev_cs_n) begin
        falls = 0; rises = 0; lows = 0; cap = 3'd0;
        word = {lead, chan[next_addr]};
      end
      lows++;
      if (!bus.adc_sck && prev_sck) begin
        if (falls < 16) dout_mdl = word[15-falls];
        falls++;
      end
      if (bus.adc_sck && !prev_sck) begin
        if (rises >= 2 && rises <= 4) cap = {cap[1:0], bus.adc_din};
        rises++;
        if (rises == 16) next_addr = cap;
      end
    end else begin
      if (bus.adc_din) din_hi_idle++;
      if (!prev_cs_n) begin
        rec_addr.push_back(cap);
        rec_falls.push_back(falls);
        rec_lows.push_back(lows);
        frames_done++;
      end
    end
    prev_cs_n = bus.adc_cs_n;
    prev_sck  = bus.adc_sck;
  end

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk_3125KHz);
      n++;
    end while (!sample_valid && n < 400);
    if (!sample_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic set_chan(input logic [11:0] c3, input logic [11:0] c2, input logic [11:0] c1);
    chan[3] = c3; chan[2] = c2; chan[1] = c1;
  endtask

  initial begin
    int n, gap_hi, n_valid, at, changes, bad;
    logic [11:0] sl, sm, sr;
    for (int i = 0; i < 8; i++) chan[i] = 12'h555;
    set_chan(12'h3E8, 12'h0C8, 12'hABC);

    // reset state
    repeat (5) @(negedge clk_3125KHz);
    chk("rst_cs_n", bus.adc_cs_n, 1);
    chk("rst_sck", bus.adc_sck, 1);
    chk("rst_din", bus.adc_din, 0);
    chk("rst_outs", {left, middle, right}, 0);
    chk("rst_valid", sample_valid, 0);

    // 1: gap after release, address sequence, 16 sck falls per frame
    rst = 1'b0;
    gap_hi = 0;
    while (bus.adc_cs_n && gap_hi < 10) begin
      gap_hi++;
      @(negedge clk_3125KHz);
    end
    chk("gap_cycles", gap_hi, 2);

    // 2: first valid after priming frame + three data frames
    wait_valid("first_valid", n);
    chk("frames_at_valid", frames_done, 4);
    if (rec_addr.size() >= 4) begin
      chk("add_f0", rec_addr[0], 3'b011);
      chk("add_f1", rec_addr[1], 3'b010);
      chk("add_f2", rec_addr[2], 3'b001);
      chk("add_f3", rec_addr[3], 3'b011);
      chk("sck_falls", rec_falls[0], 16);
      chk("frame_len", rec_lows[1], 32);
    end else chk("frame_records", rec_addr.size(), 4);
    chk("left", left, 12'h3E8);
    chk("middle", middle, 12'h0C8);
    chk("right", right, 12'hABC);

    // 3: scan period and output stability
    sl = left; sm = middle; sr = right;
    n_valid = 0; at = 0; changes = 0;
    for (int i = 1; i <= 105; i++) begin
      @(negedge clk_3125KHz);
      if (sample_valid) begin n_valid++; at = i; end
      if (i < 105 && {left, middle, right} !== {sl, sm, sr}) changes++;
    end
    chk("valid_period", at, 105);
    chk("valid_count", n_valid, 1);
    chk("out_changes", changes, 0);

    // 4: leading ones ignored; extremes pass unchanged
    lead = 4'hF;
    set_chan(12'h000, 12'h000, 12'h000);
    wait_valid("zero_a", n);
    wait_valid("zero_b", n);
    chk("zero_outs", {left, middle, right}, 36'h0);
    set_chan(12'hFFF, 12'hFFF, 12'hFFF);
    wait_valid("ones_a", n);
    wait_valid("ones_b", n);
    chk("ones_outs", {left, middle, right}, 36'hFFF_FFF_FFF);

    // 5: reset at cycle 10 of a frame
    lead = 4'h0;
    set_chan(12'h3E8, 12'h0C8, 12'hABC);
    n = 0;
    while (!bus.adc_cs_n && n < 100) begin n++; @(negedge clk_3125KHz); end
    while (bus.adc_cs_n && n < 100) begin n++; @(negedge clk_3125KHz); end
    repeat (9) @(negedge clk_3125KHz);
    chk("mid_frame", bus.adc_cs_n, 0);
    rst = 1'b1;
    @(negedge clk_3125KHz);
    chk("abort_cs_n", bus.adc_cs_n, 1);
    chk("abort_outs", {left, middle, right}, 36'h0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk_3125KHz);
      if (sample_valid || {left, middle, right} != 36'h0) bad++;
    end
    chk("prime_discard", bad, 0);
    wait_valid("post_abort", n);
    chk("post_abort_outs", {left, middle, right}, 36'h3E8_0C8_ABC);

    // 6: long reset hold
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_3125KHz);
      if (!bus.adc_cs_n || !bus.adc_sck || sample_valid) bad++;
    end
    chk("hold_rst", bad, 0);
    rst = 1'b0;
    wait_valid("after_hold", n);
    chk("after_hold_left", left, 12'h3E8);
    chk("din_idle", din_hi_idle, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
